// File: rtl/add_mul_seq_unit.sv
// Sequential unsigned add / shift-and-add multiply unit with a one-cycle done pulse.
// Define ADD_MUL_SEQ_ACC_EN to add the acc input (accumulate into the previous result).
module add_mul_seq_unit #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
`ifdef ADD_MUL_SEQ_ACC_EN
   input  logic                 acc,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      FIN
   } state_t;

   state_t state, state_next;

   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_next;
   logic [2*WIDTH-1:0] sum_ab;
   logic [2*WIDTH-1:0] add_base;
   logic [2*WIDTH-1:0] mul_base;
   logic [CW-1:0]      count;
   logic               load_add;
   logic               load_mul;
   logic               step;
   logic               finish;

   assign sum_ab    = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
   assign prod_next = mplier[count] ? (prod + ({{WIDTH{1'b0}}, mcand} << count)) : prod;

   // In accumulate mode the new value is added onto the held result; acc is
   // captured with start so a multiply uses the value present when it began.
`ifdef ADD_MUL_SEQ_ACC_EN
   logic acc_q;
   assign add_base = acc ? result : '0;
   assign mul_base = acc_q ? result : '0;
`else
   assign add_base = '0;
   assign mul_base = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      load_add   = 1'b0;
      load_mul   = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (op) begin
                  load_add   = 1'b1;
                  state_next = FIN;
               end else begin
                  load_mul   = 1'b1;
                  state_next = MUL;
               end
            end
         end
         MUL: begin
            busy = 1'b1;
            step = 1'b1;
            if (count == CW'(WIDTH - 1)) begin
               finish     = 1'b1;
               state_next = FIN;
            end
         end
         FIN: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: result is written only on the edge that enters FIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         count  <= '0;
         result <= '0;
`ifdef ADD_MUL_SEQ_ACC_EN
         acc_q  <= 1'b0;
`endif
      end else begin
         if (load_add) begin
            result <= add_base + sum_ab;
         end
         if (load_mul) begin
            mcand  <= a;
            mplier <= b;
            prod   <= '0;
            count  <= '0;
`ifdef ADD_MUL_SEQ_ACC_EN
            acc_q  <= acc;
`endif
         end
         if (step) begin
            prod  <= prod_next;
            count <= count + CW'(1);
         end
         if (finish) begin
            result <= mul_base + prod_next;
         end
      end
   end

endmodule
